result_tx: RTL and testbench

RESULT_TX -- requirements
Module: result_tx

---
 rtl/result_tx.sv | 189 ++++++++++++++++++
 tb/tb_result_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx.sv
// rtl/result_tx.sv - frames MMU result matrices and dimension errors into a byte stream
module result_tx #(
  parameter int ACC_SIZE   = 24,
  parameter int WORD_BYTES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dim_fifo_empty,
  input  logic [7:0]          dim_x_in,
  input  logic [7:0]          dim_y_in,
  output logic                dim_fifo_rd,
  input  logic                data_fifo_empty,
  input  logic [ACC_SIZE-1:0] data_in,
  output logic                data_fifo_rd,
  input  logic                dim_error,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                tx_active
);

  localparam int SH_W = WORD_BYTES * 8;
  localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [7:0]      HDR_BYTE  = 8'hA5;
  localparam logic [7:0]      ERR_BYTE  = 8'hEE;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DIMX,
    DIMY,
    LOAD,
    BYTES,
    ERR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic            r_dim_rd;
  logic            r_data_rd;
  logic            r_err_pend;
  logic [7:0]      r_dim_x;
  logic [7:0]      r_dim_y;
  logic [15:0]     r_words;
  logic [SH_W-1:0] r_shift;
  logic [BC_W-1:0] r_byte_idx;

  logic            w_tx_ready;
  logic            w_send;
  logic [7:0]      w_send_byte;
  logic            w_pop_dim;
  logic            w_pop_data;
  logic            w_load_cnt;
  logic            w_shift;
  logic            w_err_clr;
  logic [15:0]     w_prod;
  logic [SH_W-1:0] w_ext;
  logic            w_last_byte;

  // The cycle in which tx_start is high is the guard: the transmitter has
  // not yet had a chance to raise tx_busy for the byte just issued.
  assign w_tx_ready  = !tx_busy && !r_tx_start;
  assign w_prod      = 16'(r_dim_x) * 16'(r_dim_y);
  assign w_ext       = SH_W'($signed(data_in));
  assign w_last_byte = (r_byte_idx == LAST_BYTE);

  always_comb begin
    w_state_nxt = r_state;
    w_send      = 1'b0;
    w_send_byte = 8'h00;
    w_pop_dim   = 1'b0;
    w_pop_data  = 1'b0;
    w_load_cnt  = 1'b0;
    w_shift     = 1'b0;
    w_err_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_err_pend && w_tx_ready) begin
          w_state_nxt = ERR;
        end else if (!dim_fifo_empty && w_tx_ready) begin
          w_state_nxt = HDR;
          w_pop_dim   = 1'b1;
          w_send      = 1'b1;
          w_send_byte = HDR_BYTE;
        end
      end
      HDR: begin
        if (w_tx_ready) begin
          w_state_nxt = DIMX;
          w_send      = 1'b1;
          w_send_byte = r_dim_x;
        end
      end
      DIMX: begin
        if (w_tx_ready) begin
          w_state_nxt = DIMY;
          w_send      = 1'b1;
          w_send_byte = r_dim_y;
        end
      end
      DIMY: begin
        w_load_cnt  = 1'b1;
        w_state_nxt = (w_prod == 16'd0) ? IDLE : LOAD;
      end
      LOAD: begin
        if (!data_fifo_empty) begin
          w_pop_data  = 1'b1;
          w_state_nxt = BYTES;
        end
      end
      BYTES: begin
        if (w_tx_ready) begin
          w_send      = 1'b1;
          w_send_byte = r_shift[SH_W-1 -: 8];
          w_shift     = 1'b1;
          if (w_last_byte) begin
            w_state_nxt = (r_words != 16'd0) ? LOAD : IDLE;
          end
        end
      end
      ERR: begin
        w_send      = 1'b1;
        w_send_byte = ERR_BYTE;
        w_err_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_dim_rd   <= 1'b0;
      r_data_rd  <= 1'b0;
      r_err_pend <= 1'b0;
      r_dim_x    <= 8'h00;
      r_dim_y    <= 8'h00;
      r_words    <= 16'd0;
      r_shift    <= '0;
      r_byte_idx <= '0;
    end else begin
      r_tx_start <= w_send;
      r_dim_rd   <= w_pop_dim;
      r_data_rd  <= w_pop_data;
      if (w_send) begin
        r_tx_data <= w_send_byte;
      end
      // A pulse arriving on the clearing edge survives and yields another 0xEE.
      r_err_pend <= dim_error || (r_err_pend && !w_err_clr);
      if (w_pop_dim) begin
        r_dim_x <= dim_x_in;
        r_dim_y <= dim_y_in;
      end
      if (w_load_cnt) begin
        r_words <= w_prod;
      end else if (w_pop_data) begin
        r_words <= r_words - 16'd1;
      end
      if (w_pop_data) begin
        r_shift    <= w_ext;
        r_byte_idx <= '0;
      end else if (w_shift) begin
        r_shift    <= r_shift << 8;
        r_byte_idx <= r_byte_idx + BC_W'(1);
      end
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign dim_fifo_rd  = r_dim_rd;
  assign data_fifo_rd = r_data_rd;
  assign tx_active    = (r_state != IDLE);

endmodule

// File: tb/tb_result_tx.sv
// tb/tb_result_tx.sv - scoreboard bench for result_tx with FWFT FIFO and busy transmitter models
module tb_result_tx;

  localparam int BUSY  = 4;
  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dim_fifo_empty;
  logic [7:0]  dim_x_in;
  logic [7:0]  dim_y_in;
  logic        dim_fifo_rd;
  logic        data_fifo_empty;
  logic [23:0] data_in;
  logic        data_fifo_rd;
  logic        dim_error;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_active;

  logic        b_dim_fifo_empty;
  logic [7:0]  b_dim_x_in;
  logic [7:0]  b_dim_y_in;
  logic        b_dim_fifo_rd;
  logic        b_data_fifo_empty;
  logic [19:0] b_data_in;
  logic        b_data_fifo_rd;
  logic        b_dim_error;
  logic        b_tx_busy;
  logic        b_tx_start;
  logic [7:0]  b_tx_data;
  logic        b_tx_active;

  logic [15:0] dq[$];
  logic [23:0] wq[$];
  logic [7:0]  exp_q[$];
  logic [15:0] b_dq[$];
  logic [19:0] b_wq[$];
  logic [7:0]  b_exp_q[$];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_start  = 0;
  int   n_dim_rd = 0;
  int   n_data_rd = 0;
  int   busy_cnt = 0;
  logic prev_start = 1'b0;
  logic b_prev_start = 1'b0;

  always #5 clk = ~clk;

  result_tx #(.ACC_SIZE(24), .WORD_BYTES(3)) u_dut (
    .clk(clk), .rst(rst),
    .dim_fifo_empty(dim_fifo_empty), .dim_x_in(dim_x_in), .dim_y_in(dim_y_in),
    .dim_fifo_rd(dim_fifo_rd),
    .data_fifo_empty(data_fifo_empty), .data_in(data_in), .data_fifo_rd(data_fifo_rd),
    .dim_error(dim_error), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active)
  );

  result_tx #(.ACC_SIZE(20), .WORD_BYTES(3)) u_dut20 (
    .clk(clk), .rst(rst),
    .dim_fifo_empty(b_dim_fifo_empty), .dim_x_in(b_dim_x_in), .dim_y_in(b_dim_y_in),
    .dim_fifo_rd(b_dim_fifo_rd),
    .data_fifo_empty(b_data_fifo_empty), .data_in(b_data_in), .data_fifo_rd(b_data_fifo_rd),
    .dim_error(b_dim_error), .tx_busy(b_tx_busy),
    .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_active(b_tx_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    dim_fifo_empty    = (dq.size() == 0);
    dim_x_in          = (dq.size() != 0) ? dq[0][15:8] : 8'h00;
    dim_y_in          = (dq.size() != 0) ? dq[0][7:0] : 8'h00;
    data_fifo_empty   = (wq.size() == 0);
    data_in           = (wq.size() != 0) ? wq[0] : 24'h0;
    b_dim_fifo_empty  = (b_dq.size() == 0);
    b_dim_x_in        = (b_dq.size() != 0) ? b_dq[0][15:8] : 8'h00;
    b_dim_y_in        = (b_dq.size() != 0) ? b_dq[0][7:0] : 8'h00;
    b_data_fifo_empty = (b_wq.size() == 0);
    b_data_in         = (b_wq.size() != 0) ? b_wq[0] : 20'h0;
  endtask

  // One clock: sample and score outputs at the falling edge, then update
  // the FIFO and transmitter models just after the rising edge.
  task automatic cyc();
    logic       pd, pw, ps, bpd, bpw;
    logic [8:0] expb;
    @(negedge clk);
    pd = dim_fifo_rd; pw = data_fifo_rd; ps = tx_start;
    bpd = b_dim_fifo_rd; bpw = b_data_fifo_rd;
    if (pd) begin n_dim_rd++; check("dim_rd_when_empty", 32'(dim_fifo_empty), 0); end
    if (pw) begin n_data_rd++; check("data_rd_when_empty", 32'(data_fifo_empty), 0); end
    if (bpw) check("b_data_rd_when_empty", 32'(b_data_fifo_empty), 0);
    if (tx_start) begin
      n_start++;
      check("tx_start_back_to_back", 32'(prev_start), 0);
      if (exp_q.size() != 0) expb = {1'b0, exp_q.pop_front()};
      else expb = 9'h100;
      check("tx_byte", 32'({1'b0, tx_data}), 32'(expb));
    end
    if (b_tx_start) begin
      check("b_tx_start_back_to_back", 32'(b_prev_start), 0);
      if (b_exp_q.size() != 0) expb = {1'b0, b_exp_q.pop_front()};
      else expb = 9'h100;
      check("b_tx_byte", 32'({1'b0, b_tx_data}), 32'(expb));
    end
    prev_start   = tx_start;
    b_prev_start = b_tx_start;
    @(posedge clk);
    #1;
    if (pd && dq.size() != 0) void'(dq.pop_front());
    if (pw && wq.size() != 0) void'(wq.pop_front());
    if (bpd && b_dq.size() != 0) void'(b_dq.pop_front());
    if (bpw && b_wq.size() != 0) void'(b_wq.pop_front());
    if (busy_cnt > 0) busy_cnt--;
    if (ps) busy_cnt = BUSY;
    tx_busy = (busy_cnt > 0);
    refresh();
  endtask

  task automatic push_dims(input logic [7:0] x, input logic [7:0] y, input bit exp);
    dq.push_back({x, y});
    if (exp) begin
      exp_q.push_back(8'hA5); exp_q.push_back(x); exp_q.push_back(y);
    end
    refresh();
  endtask

  task automatic push_word(input logic [23:0] w, input bit fifo, input bit exp);
    if (fifo) wq.push_back(w);
    if (exp) begin
      exp_q.push_back(w[23:16]); exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]);
    end
    refresh();
  endtask

  task automatic wait_starts(input string tag, input int n);
    int base = n_start;
    int k = 0;
    while ((n_start - base) < n && k < LIMIT) begin cyc(); k++; end
    check({tag, "_reached"}, 32'(k < LIMIT), 1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || tx_active || b_exp_q.size() != 0 || b_tx_active) && k < LIMIT) begin
      cyc(); k++;
    end
    check({tag, "_drained"}, 32'(k < LIMIT), 1);
  endtask

  initial begin
    int d0, w0, s0;
    rst = 1'b1; dim_error = 1'b0; tx_busy = 1'b0;
    b_dim_error = 1'b0; b_tx_busy = 1'b0;
    refresh();
    repeat (3) cyc();
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_dim_rd", 32'(dim_fifo_rd), 0);
    check("rst_data_rd", 32'(data_fifo_rd), 0);
    check("rst_tx_active", 32'(tx_active), 0);
    rst = 1'b0;
    repeat (2) cyc();

    // 2x3 matrix, words 1..6
    d0 = n_dim_rd; w0 = n_data_rd;
    push_dims(8'd2, 8'd3, 1'b1);
    for (int i = 1; i <= 6; i++) push_word(24'(i), 1'b1, 1'b1);
    cyc();
    check("hdr_latency_start", 32'(tx_start), 1);
    check("hdr_latency_byte", 32'(tx_data), 32'hA5);
    check("hdr_dim_rd", 32'(dim_fifo_rd), 1);
    check("frame_active", 32'(tx_active), 1);
    drain("frame_2x3");
    check("frame_2x3_dim_pops", 32'(n_dim_rd - d0), 1);
    check("frame_2x3_data_pops", 32'(n_data_rd - w0), 6);

    // most negative word, and sign extension on the 20-bit instance
    push_dims(8'd1, 8'd1, 1'b1);
    push_word(24'h800000, 1'b1, 1'b1);
    b_dq.push_back({8'd1, 8'd2});
    b_wq.push_back(20'h80000); b_wq.push_back(20'hF8000);
    b_exp_q.push_back(8'hA5); b_exp_q.push_back(8'h01); b_exp_q.push_back(8'h02);
    b_exp_q.push_back(8'hF8); b_exp_q.push_back(8'h00); b_exp_q.push_back(8'h00);
    b_exp_q.push_back(8'hFF); b_exp_q.push_back(8'h80); b_exp_q.push_back(8'h00);
    refresh();
    drain("sign_ext");

    // two error pulses during the second data byte coalesce after the frame
    push_dims(8'd1, 8'd2, 1'b1);
    push_word(24'h123456, 1'b1, 1'b1);
    push_word(24'hFEDCBA, 1'b1, 1'b1);
    wait_starts("err_mid", 5);
    dim_error = 1'b1; exp_q.push_back(8'hEE);
    cyc();
    dim_error = 1'b0;
    repeat (3) cyc();
    dim_error = 1'b1;
    cyc();
    dim_error = 1'b0;
    drain("err_coalesce");

    // error pulse on the edge that sends 0xEE produces a second 0xEE
    repeat (8) cyc();
    dim_error = 1'b1;
    cyc();
    dim_error = 1'b0;
    cyc();
    check("err_state_active", 32'(tx_active), 1);
    check("err_state_no_start", 32'(tx_start), 0);
    dim_error = 1'b1; exp_q.push_back(8'hEE); exp_q.push_back(8'hEE);
    cyc();
    dim_error = 1'b0;
    drain("err_repeat");
    s0 = n_start;
    repeat (20) cyc();
    check("err_cleared_quiet", 32'(n_start), 32'(s0));

    // data FIFO runs dry after the second word
    push_dims(8'd1, 8'd4, 1'b1);
    push_word(24'hA1B2C3, 1'b1, 1'b1);
    push_word(24'h7F0001, 1'b1, 1'b1);
    push_word(24'h00FF00, 1'b0, 1'b1);
    push_word(24'hC0FFEE, 1'b0, 1'b1);
    wait_starts("stall", 9);
    s0 = n_start;
    repeat (50) cyc();
    check("stall_no_tx", 32'(n_start), 32'(s0));
    check("stall_active", 32'(tx_active), 1);
    push_word(24'h00FF00, 1'b1, 1'b0);
    push_word(24'hC0FFEE, 1'b1, 1'b0);
    drain("stall_resume");

    // zero-row matrix: header only, data FIFO untouched
    w0 = n_data_rd;
    push_word(24'h0000AA, 1'b1, 1'b0);
    push_dims(8'd0, 8'd5, 1'b1);
    drain("zero_dims");
    check("zero_dims_no_pop", 32'(n_data_rd - w0), 0);
    check("zero_dims_fifo_kept", 32'(wq.size()), 1);
    wq.delete();
    refresh();

    // reset after DIMX aborts the frame silently
    repeat (8) cyc();
    dq.push_back({8'd2, 8'd1});
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02);
    push_word(24'h111111, 1'b1, 1'b0);
    push_word(24'h222222, 1'b1, 1'b0);
    wait_starts("abort", 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_tx_start", 32'(tx_start), 0);
    check("abort_tx_data", 32'(tx_data), 0);
    check("abort_tx_active", 32'(tx_active), 0);
    check("abort_dim_rd", 32'(dim_fifo_rd), 0);
    check("abort_data_rd", 32'(data_fifo_rd), 0);
    s0 = n_start;
    repeat (40) cyc();
    check("abort_quiet", 32'(n_start), 32'(s0));
    check("abort_fifo_kept", 32'(wq.size()), 2);
    check("abort_exp_consumed", 32'(exp_q.size()), 0);
    push_dims(8'd1, 8'd2, 1'b1);
    push_word(24'h111111, 1'b0, 1'b1);
    push_word(24'h222222, 1'b0, 1'b1);
    drain("after_abort");
    check("after_abort_fifo_empty", 32'(wq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
